// File: rtl/uart_cmd_system_pkg.sv
// Shared definitions for the UART command system: command codes,
// ALU opcodes, controller states and the serial frame length.
package uart_cmd_system_pkg;

   localparam logic [7:0] CMD_WRITE   = 8'hAA;
   localparam logic [7:0] CMD_READ    = 8'hBB;
   localparam logic [7:0] CMD_ALU     = 8'hCC;
   localparam logic [7:0] CMD_ALU_RUN = 8'hDD;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR,
      OP_EQ, OP_GT, OP_LT,
      OP_SHR, OP_SHL, OP_ZERO
   } alu_op_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A, ST_ALU_B, ST_ALU_FUN
   } ctrl_state_t;

   // start + payload + even parity + stop
   function automatic int frame_bits(input int w);
      return w + 3;
   endfunction

endpackage

// File: rtl/uart_bit_engine.sv
// Serial bit engine shared by receiver and transmitter: bit timing, shifting
// and even parity. TX_MODE selects which half of the behaviour is active.
module uart_bit_engine
   import uart_cmd_system_pkg::*;
#(
   parameter int width        = 8,
   parameter int CLKS_PER_BIT = 8,
   parameter bit TX_MODE      = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_in,
   input  logic             load,
   input  logic [width-1:0] load_data,
   output logic             line_out,
   output logic             ready,
   output logic [width-1:0] data,
   output logic             data_valid,
   output logic             parity_error,
   output logic             stop_error
);

   localparam int FB = frame_bits(width);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = $clog2(FB);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
   localparam logic [IW-1:0] IDX_LAST = IW'(FB - 1);

   logic          active;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [FB-1:0] shifter;
   logic [1:0]    sync;
   logic          prev;
   logic          sample;
   logic [FB-1:0] frame;

   assign sample = sync[1];
   assign frame  = {sample, shifter[FB-1:1]};
   // Ready on the final tick of the stop bit lets the next frame follow with no gap.
   assign ready  = !active || (cnt == CNT_LAST && idx == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active       <= 1'b0;
         cnt          <= '0;
         idx          <= '0;
         shifter      <= '0;
         line_out     <= 1'b1;
         sync         <= 2'b11;
         prev         <= 1'b1;
         data         <= '0;
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
      end else begin
         data_valid   <= 1'b0;
         parity_error <= 1'b0;
         stop_error   <= 1'b0;
         sync         <= {sync[0], line_in};
         prev         <= sample;
         if (TX_MODE) begin
            if (load && ready) begin
               shifter  <= {1'b1, ^load_data, load_data, 1'b0};
               line_out <= 1'b0;
               active   <= 1'b1;
               cnt      <= '0;
               idx      <= '0;
            end else if (active) begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     active <= 1'b0;
                  end else begin
                     idx      <= idx + 1'b1;
                     shifter  <= shifter >> 1;
                     line_out <= shifter[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         end else if (!active) begin
            // The edge-detect cycle counts as tick 0 of the start bit.
            if (prev && !sample) begin
               active <= 1'b1;
               cnt    <= CW'(1);
               idx    <= '0;
            end
         end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_MID) begin
               shifter <= frame;
               idx     <= idx + 1'b1;
               if (idx == '0 && sample) begin
                  active <= 1'b0;
               end else if (idx == IDX_LAST) begin
                  active       <= 1'b0;
                  data         <= frame[width:1];
                  parity_error <= (^frame[width:1]) != frame[width+1];
                  stop_error   <= !sample;
                  data_valid   <= sample && ((^frame[width:1]) == frame[width+1]);
               end
            end
         end
      end
   end

endmodule

// File: rtl/uart_cmd_system.sv
// UART-driven register file / ALU: decodes command bytes from the receiver and
// returns read data and ALU results through a 4-byte FIFO and the transmitter.
module uart_cmd_system
   import uart_cmd_system_pkg::*;
#(
   parameter int width        = 8,
   parameter int depth        = 16,
   parameter int CLKS_PER_BIT = 8
) (
   input  logic REF_CLK,
   input  logic Reset,
   input  logic Rx_IN,
   output logic Tx_out,
   output logic Parity_error,
   output logic Stop_error
);

   localparam int AW         = $clog2(depth);
   localparam int FIFO_DEPTH = 4;

   logic [width-1:0]   rx_data;
   logic               rx_valid;
   logic               tx_ready;
   logic               tx_load;
   logic [width-1:0]   tx_data;
   logic               rx_unused_line;
   logic               rx_unused_ready;
   logic [width-1:0]   tx_unused_data;
   logic               tx_unused_valid;
   logic               tx_unused_perr;
   logic               tx_unused_serr;

   ctrl_state_t        state;
   logic [width-1:0]   regs [depth];
   logic [AW-1:0]      wr_addr;
   logic [2*width-1:0] alu_result;
   logic [2*width-1:0] alu_next;
   logic               hi_pending;
   logic               enq_valid;
   logic [width-1:0]   enq_data;

   logic [width-1:0]   fifo [FIFO_DEPTH];
   logic [1:0]         wr_ptr;
   logic [1:0]         rd_ptr;
   logic [2:0]         count;
   logic               push;

   function automatic logic [2*width-1:0] alu_calc(input alu_op_t op,
                                                   input logic [width-1:0] a,
                                                   input logic [width-1:0] b);
      logic [2*width-1:0] ea;
      logic [2*width-1:0] eb;
      ea = {{width{1'b0}}, a};
      eb = {{width{1'b0}}, b};
      case (op)
         OP_ADD:  return ea + eb;
         OP_SUB:  return ea - eb;
         OP_MUL:  return ea * eb;
         OP_DIV:  return (b == '0) ? '0 : ea / eb;
         OP_AND:  return ea & eb;
         OP_OR:   return ea | eb;
         OP_NAND: return {{width{1'b0}}, ~(a & b)};
         OP_NOR:  return {{width{1'b0}}, ~(a | b)};
         OP_XOR:  return ea ^ eb;
         OP_XNOR: return {{width{1'b0}}, ~(a ^ b)};
         OP_EQ:   return (a == b) ? (2*width)'(1) : '0;
         OP_GT:   return (a > b)  ? (2*width)'(1) : '0;
         OP_LT:   return (a < b)  ? (2*width)'(1) : '0;
         OP_SHR:  return ea >> 1;
         OP_SHL:  return ea << 1;
         default: return '0;
      endcase
   endfunction

   assign alu_next = alu_calc(alu_op_t'(rx_data[3:0]), regs[0], regs[1]);

   uart_bit_engine #(.width(width), .CLKS_PER_BIT(CLKS_PER_BIT), .TX_MODE(1'b0)) u_rx (
      .clk          (REF_CLK),
      .rst_n        (Reset),
      .line_in      (Rx_IN),
      .load         (1'b0),
      .load_data    ('0),
      .line_out     (rx_unused_line),
      .ready        (rx_unused_ready),
      .data         (rx_data),
      .data_valid   (rx_valid),
      .parity_error (Parity_error),
      .stop_error   (Stop_error)
   );

   uart_bit_engine #(.width(width), .CLKS_PER_BIT(CLKS_PER_BIT), .TX_MODE(1'b1)) u_tx (
      .clk          (REF_CLK),
      .rst_n        (Reset),
      .line_in      (1'b1),
      .load         (tx_load),
      .load_data    (tx_data),
      .line_out     (Tx_out),
      .ready        (tx_ready),
      .data         (tx_unused_data),
      .data_valid   (tx_unused_valid),
      .parity_error (tx_unused_perr),
      .stop_error   (tx_unused_serr)
   );

   // Controller: one transition per accepted byte; ALU high byte queued a cycle after the low byte.
   always_ff @(posedge REF_CLK or negedge Reset) begin
      if (!Reset) begin
         state      <= ST_IDLE;
         wr_addr    <= '0;
         alu_result <= '0;
         hi_pending <= 1'b0;
         enq_valid  <= 1'b0;
         enq_data   <= '0;
         for (int i = 0; i < depth; i++) regs[i] <= '0;
      end else begin
         enq_valid <= 1'b0;
         if (hi_pending) begin
            enq_valid  <= 1'b1;
            enq_data   <= alu_result[2*width-1:width];
            hi_pending <= 1'b0;
         end
         if (rx_valid) begin
            case (state)
               ST_IDLE: begin
                  if (rx_data == CMD_WRITE)        state <= ST_WR_ADDR;
                  else if (rx_data == CMD_READ)    state <= ST_RD_ADDR;
                  else if (rx_data == CMD_ALU)     state <= ST_ALU_A;
                  else if (rx_data == CMD_ALU_RUN) state <= ST_ALU_FUN;
               end
               ST_WR_ADDR: begin
                  wr_addr <= rx_data[AW-1:0];
                  state   <= ST_WR_DATA;
               end
               ST_WR_DATA: begin
                  regs[wr_addr] <= rx_data;
                  state         <= ST_IDLE;
               end
               ST_RD_ADDR: begin
                  enq_valid <= 1'b1;
                  enq_data  <= regs[rx_data[AW-1:0]];
                  state     <= ST_IDLE;
               end
               ST_ALU_A: begin
                  regs[0] <= rx_data;
                  state   <= ST_ALU_B;
               end
               ST_ALU_B: begin
                  regs[1] <= rx_data;
                  state   <= ST_ALU_FUN;
               end
               ST_ALU_FUN: begin
                  alu_result <= alu_next;
                  enq_valid  <= 1'b1;
                  enq_data   <= alu_next[width-1:0];
                  hi_pending <= 1'b1;
                  state      <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign push    = enq_valid && (count != 3'(FIFO_DEPTH));
   assign tx_load = tx_ready && (count != '0);
   assign tx_data = fifo[rd_ptr];

   // Output FIFO: bytes arriving while full are dropped.
   always_ff @(posedge REF_CLK or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= enq_data;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (tx_load) rd_ptr <= rd_ptr + 1'b1;
         case ({push, tx_load})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_system.sv
// Directed bench for uart_cmd_system: drives serial command frames and decodes
// the returned serial frames against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_cmd_system;

   localparam int CPB = 8;

   logic REF_CLK = 1'b0;
   logic Reset   = 1'b0;
   logic Rx_IN   = 1'b1;
   logic Tx_out;
   logic Parity_error;
   logic Stop_error;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       s;
   } frame_t;

   frame_t q[$];
   int compared   = 0;
   int mismatched = 0;
   int perr_cnt   = 0;
   int serr_cnt   = 0;

   uart_cmd_system #(.width(8), .depth(16), .CLKS_PER_BIT(CPB)) dut (
      .REF_CLK      (REF_CLK),
      .Reset        (Reset),
      .Rx_IN        (Rx_IN),
      .Tx_out       (Tx_out),
      .Parity_error (Parity_error),
      .Stop_error   (Stop_error)
   );

   always #5 REF_CLK = ~REF_CLK;

   always @(negedge REF_CLK) begin
      if (Parity_error === 1'b1) perr_cnt++;
      if (Stop_error === 1'b1) serr_cnt++;
   end

   // Serial decoder for Tx_out
   initial begin
      forever begin
         logic [10:0] bits;
         @(negedge Tx_out);
         if (Reset !== 1'b1) continue;
         repeat (CPB/2) @(negedge REF_CLK);
         bits[0] = Tx_out;
         for (int i = 1; i < 11; i++) begin
            repeat (CPB) @(negedge REF_CLK);
            bits[i] = Tx_out;
         end
         if (bits[0] == 1'b0) q.push_back({bits[8:1], bits[9], bits[10]});
      end
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
      logic [10:0] fr;
      fr = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         Rx_IN = fr[i];
         repeat (CPB) @(negedge REF_CLK);
      end
      Rx_IN = 1'b1;
      repeat (2*CPB) @(negedge REF_CLK);
   endtask

   task automatic wait_frames(input string tag, input int n);
      int t = 0;
      while (q.size() < n && t < 800) begin
         @(negedge REF_CLK);
         t++;
      end
      repeat (3*CPB) @(negedge REF_CLK);
      check({tag, " frame count"}, 16'(q.size()), 16'(n));
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] d);
      frame_t f;
      if (q.size() > 0) f = q.pop_front();
      else f = 'x;
      check({tag, " data"}, 16'(f.d), 16'(d));
      check({tag, " parity"}, 16'(f.p), 16'(^d));
      check({tag, " stop"}, 16'(f.s), 16'h1);
   endtask

   initial begin
      logic [10:0] part;
      int p0;
      int s0;

      repeat (3) @(negedge REF_CLK);
      check("reset tx_out", 16'(Tx_out), 16'h1);
      check("reset parity_error", 16'(Parity_error), 16'h0);
      check("reset stop_error", 16'(Stop_error), 16'h0);
      Reset = 1'b1;
      repeat (4) @(negedge REF_CLK);

      // reg3 = 0x55, read back
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h55);
      send_byte(8'hBB); send_byte(8'h03);
      wait_frames("read reg3", 1);
      expect_frame("read reg3", 8'h55);

      // reset in the middle of a write-data frame
      send_byte(8'hAA); send_byte(8'h03);
      part = {1'b1, ^8'h77, 8'h77, 1'b0};
      for (int i = 0; i < 4; i++) begin
         Rx_IN = part[i];
         repeat (CPB) @(negedge REF_CLK);
      end
      Reset = 1'b0;
      Rx_IN = 1'b1;
      repeat (2) @(negedge REF_CLK);
      check("mid reset tx_out", 16'(Tx_out), 16'h1);
      check("mid reset errors", 16'({Parity_error, Stop_error}), 16'h0);
      Reset = 1'b1;
      repeat (4*CPB) @(negedge REF_CLK);
      check("no spurious tx after reset", 16'(q.size()), 16'h0);
      send_byte(8'hBB); send_byte(8'h03);
      wait_frames("reg3 cleared", 1);
      expect_frame("reg3 cleared", 8'h00);
      send_byte(8'hDD); send_byte(8'h00);
      wait_frames("reg0+reg1 cleared", 2);
      expect_frame("reg0+reg1 lo", 8'h00);
      expect_frame("reg0+reg1 hi", 8'h00);

      // write/read reg10
      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h0A);
      send_byte(8'hBB); send_byte(8'h0A);
      wait_frames("read reg10", 1);
      expect_frame("read reg10", 8'h0A);

      // 15 + 255 = 0x010E
      send_byte(8'hCC); send_byte(8'h0F); send_byte(8'hFF); send_byte(8'h00);
      wait_frames("add", 2);
      expect_frame("add lo", 8'h0E);
      expect_frame("add hi", 8'h01);

      // 8 * 128 = 0x0400, then compares on existing operands
      send_byte(8'hCC); send_byte(8'h08); send_byte(8'h80); send_byte(8'h02);
      wait_frames("mul", 2);
      expect_frame("mul lo", 8'h00);
      expect_frame("mul hi", 8'h04);
      send_byte(8'hDD); send_byte(8'h0B);
      wait_frames("gt", 2);
      expect_frame("gt lo", 8'h00);
      expect_frame("gt hi", 8'h00);
      send_byte(8'hDD); send_byte(8'h0C);
      wait_frames("lt", 2);
      expect_frame("lt lo", 8'h01);
      expect_frame("lt hi", 8'h00);

      // bad parity then bad stop: both discarded
      p0 = perr_cnt;
      s0 = serr_cnt;
      send_byte(8'hBB, 1'b1, 1'b0);
      send_byte(8'hAA, 1'b0, 1'b1);
      repeat (4*CPB) @(negedge REF_CLK);
      check("parity_error pulses", 16'(perr_cnt - p0), 16'h1);
      check("stop_error pulses", 16'(serr_cnt - s0), 16'h1);
      check("no tx after bad frames", 16'(q.size()), 16'h0);
      send_byte(8'hBB); send_byte(8'h0A);
      wait_frames("read after errors", 1);
      expect_frame("read after errors", 8'h0A);

      // short low glitch on Rx_IN
      p0 = perr_cnt;
      s0 = serr_cnt;
      Rx_IN = 1'b0;
      repeat (2) @(negedge REF_CLK);
      Rx_IN = 1'b1;
      repeat (3*CPB) @(negedge REF_CLK);
      check("glitch errors", 16'((perr_cnt - p0) + (serr_cnt - s0)), 16'h0);
      check("glitch no tx", 16'(q.size()), 16'h0);
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h00); send_byte(8'h03);
      wait_frames("div by zero", 2);
      expect_frame("div by zero lo", 8'h00);
      expect_frame("div by zero hi", 8'h00);
      check("final tx idle", 16'(Tx_out), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
